// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory busywait bus between the fetch unit and the memory.
interface instr_fetch_unit_if;
   logic        IMEM_READ;
   logic [31:0] IMEM_ADDRESS;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT;

   modport master (
      output IMEM_READ,
      output IMEM_ADDRESS,
      input  IMEM_READDATA,
      input  IMEM_BUSYWAIT
   );

   modport slave (
      input  IMEM_READ,
      input  IMEM_ADDRESS,
      output IMEM_READDATA,
      output IMEM_BUSYWAIT
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage and IF/ID register: owns the fetch PC, issues word reads
// over the busywait bus, buffers one word under decode stall and drops an
// in-flight read after a redirect.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   STALL,
   input  logic                   BRANCH_TAKEN,
   input  logic [31:0]            BRANCH_TARGET,
   instr_fetch_unit_if.master     IMEM,
   output logic                   IFID_VALID,
   output logic [31:0]            IFID_INSTRUCTION,
   output logic [31:0]            IFID_PC,
   output logic [31:0]            IFID_PC4
);

   typedef enum logic {FETCH, DISCARD} state_t;

   state_t      state_q, state_d;
   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] disc_addr_q, disc_addr_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;

   logic        read;
   logic [31:0] addr;
   logic        complete;
   logic [31:0] target_aligned;

   // Memory request: no new read while a word sits in the buffer.
   always_comb begin
      read     = !RESET && ((state_q == FETCH && !buf_valid_q) || state_q == DISCARD);
      addr     = (state_q == DISCARD) ? disc_addr_q : f_pc_q;
      complete = read && !IMEM.IMEM_BUSYWAIT;
   end

   assign target_aligned    = BRANCH_TARGET & ~32'h0000_0003;
   assign IMEM.IMEM_READ    = read;
   assign IMEM.IMEM_ADDRESS = addr;
   assign IFID_VALID        = ifid_valid_q;
   assign IFID_INSTRUCTION  = ifid_instr_q;
   assign IFID_PC           = ifid_pc_q;
   assign IFID_PC4          = ifid_pc4_q;

   // Next-state: redirect beats stall; DISCARD only drains the stale read.
   always_comb begin
      state_d      = state_q;
      f_pc_d       = f_pc_q;
      disc_addr_d  = disc_addr_q;
      buf_valid_d  = buf_valid_q;
      buf_instr_d  = buf_instr_q;
      buf_pc_d     = buf_pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;

      if (BRANCH_TAKEN) begin
         f_pc_d       = target_aligned;
         buf_valid_d  = 1'b0;
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
         // A read still waiting on memory must be drained before refetching.
         if (state_q == FETCH && read && IMEM.IMEM_BUSYWAIT) begin
            disc_addr_d = f_pc_q;
            state_d     = DISCARD;
         end
      end else if (state_q == DISCARD) begin
         if (complete) begin
            state_d = FETCH;
         end
         if (!STALL) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
         end
      end else begin
         if (complete) begin
            f_pc_d = f_pc_q + 32'd4;
            if (STALL) begin
               buf_valid_d = 1'b1;
               buf_instr_d = IMEM.IMEM_READDATA;
               buf_pc_d    = f_pc_q;
            end
         end
         if (!STALL) begin
            if (buf_valid_q) begin
               buf_valid_d  = 1'b0;
               ifid_valid_d = 1'b1;
               ifid_instr_d = buf_instr_q;
               ifid_pc_d    = buf_pc_q;
               ifid_pc4_d   = buf_pc_q + 32'd4;
            end else if (complete) begin
               ifid_valid_d = 1'b1;
               ifid_instr_d = IMEM.IMEM_READDATA;
               ifid_pc_d    = f_pc_q;
               ifid_pc4_d   = f_pc_q + 32'd4;
            end else begin
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= FETCH;
         f_pc_q       <= RESET_PC;
         disc_addr_q  <= '0;
         buf_valid_q  <= 1'b0;
         buf_instr_q  <= NOP_INSTR;
         buf_pc_q     <= '0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= 32'd4;
      end else begin
         state_q      <= state_d;
         f_pc_q       <= f_pc_d;
         disc_addr_q  <= disc_addr_d;
         buf_valid_q  <= buf_valid_d;
         buf_instr_q  <= buf_instr_d;
         buf_pc_q     <= buf_pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
      end
   end

endmodule
